r2sdf_stage: RTL and testbench
==============================

# r2sdf_stage

Parametrised radix-2 single-path delay-feedback (R2SDF) butterfly stage with its own sample counter, input/output valid strobes, stall tolerance and optional 1/2 scaling. It replaces the externally-selected, fixed-width SDF unit. Stages are chained with DELAY_DEPTH halving per stage. Twiddle multipliers sit between stages and are outside this block.

## Interface
- DATA_WIDTH, 16: signed two's-complement width of each real/imag component, in and out.
- DELAY_DEPTH, 8: feedback delay length N in samples. Power of two, at least 1. Frame length is 2N.

Ports:
- clk  in  1  master clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- di_en  in  1  input sample valid; a sample is accepted on every clk edge with di_en=1.
- di_re  in  DATA_WIDTH  input real.
- di_im  in  DATA_WIDTH  input imag.
- do_en  out  1  output sample valid (registered).
- do_re  out  DATA_WIDTH  output real (registered).
- do_im  out  DATA_WIDTH  output imag (registered).
- do_sel  out  1  registered copy of the select phase for the emitted sample, for the next stage's twiddle/control.

## Operation
- cnt: counter of width log2(2N), incremented once per accepted sample and wrapping at 2N-1→0.
- sel = cnt[log2(N)] (MSB). sel=0 for first-half samples 0..N-1, sel=1 for second-half samples N..2N-1. For N=1, sel = cnt[0].
- Delay line: N-entry complex shift register. It shifts only on accepted samples and holds on di_en=0. x1 is the oldest entry.
- Butterfly is computed at DATA_WIDTH+1 bits:
  - y0 = x0 + x1.
  - y1 = x1 − x0.
  - x0 is the current input.
- sel=0: delay line is written with x0; the output is x1 (the previous frame's y1 drained out).
- sel=1: delay line is written with y1 (after width reduction); the output is y0 (after width reduction).
- Width reduction without scaling: keep the low DATA_WIDTH bits (modular wrap). The x1 pass-through is unaffected.
- primed flag:
  - Cleared by reset.
  - Set on the accepted sample that makes cnt wrap from N-1 to N, i.e. the first sel=1 sample.
  - Stays set until the next reset.
- Outputs are registered from the accepted sample:
  - do_en = primed-or-being-set AND di_en.
  - do_sel = sel of that sample.
- Reset (asynchronous, any time, including mid-frame) clears:
  - cnt=0, primed=0.
  - All delay entries = 0.
  - do_en=0, do_re=0, do_im=0, do_sel=0.
- The first sample accepted after reset is frame sample 0.
- No back-pressure. The downstream stage must accept every do_en pulse.

## Timing
- Latency: 1 clk from accepted input to its output register.
- Sample k of a frame appears N accepted samples later in stream order:
  - second half yields y0;
  - the next frame's first half yields y1.
- First do_en=1: 1 clk after the (N+1)-th accepted sample following reset.
- Stall (di_en=0): cnt, delay line, primed and the output data registers hold; do_en=0 the next cycle.
- Back-to-back di_en=1: one output per cycle once primed.
- cnt wrap at 2N-1 is seamless. The next frame's sample 0 is sel=0 and outputs the stored y1 of sample 0 of the previous frame.

## Configuration
- SDF_SCALE_EN defined:
  - both y0 and the stored y1 become (v + 1) >>> 1, computed at DATA_WIDTH+1 bits (round half up);
  - the result always fits DATA_WIDTH, so no saturation logic is needed;
  - the x1 pass-through on sel=0 is unscaled.
- SDF_SCALE_EN undefined: modular truncation as described in Operation. Bit-exact with the legacy unit.

## Structure
- Shared package sdf_pkg holds:
  - the clog2 constant function;
  - the complex-sample typedef/width macros (DATA_WIDTH default);
  - the scale/round helper function.
- One sub-module: sdf_delay_line (parameters DATA_WIDTH, DELAY_DEPTH). Enable-gated complex shift register with async reset to zero.
- Counter, butterfly, muxing and output registers stay in r2sdf_stage.

## Test plan
All scenarios use DATA_WIDTH=16, DELAY_DEPTH=4 unless noted.
- Reset: assert rst asynchronously mid-cycle → do_en, do_re, do_im, do_sel = 0 immediately and held while rst=1.
- Impulse: continuous frames [1,0,0,0,0,0,0,0] real.
  - First do_en one clk after input 4.
  - Outputs re = 1,0,0,0 (do_sel=1), then 1,0,0,0 (do_sel=0), and so on.
  - Same values with SDF_SCALE_EN.
- DC: constant 100+j50.
  - sel=1 outputs are 200+j100, sel=0 outputs are 0.
  - With SDF_SCALE_EN: 100+j50 and 0.
- Overflow: 32767 in both halves.
  - Without macro: y0 = 0xFFFE (−2).
  - With SDF_SCALE_EN: 32767.
  - Input −32768 in both halves: y0 = 0 without the macro, −32768 with it.
- Stalls: random di_en gaps of 1–3 cycles over 3 frames → do_re/do_im sequence identical to the gap-free run, do_en low one clk after each gap cycle.
- Mid-frame reset at input 6 → do_en stays 0 until one clk after 5 new accepted samples; stale delay data never appears (first sel=0 outputs after re-prime are computed from post-reset samples only).

Source files
------------

// File: rtl/sdf_pkg.sv
// Shared definitions for the R2SDF pipeline: width helper, default complex sample type,
// and the optional half-scale rounding used when SDF_SCALE_EN is defined.
package sdf_pkg;

   localparam int SDF_DATA_WIDTH = 16;
   localparam int SDF_CALC_WIDTH = 32;

   typedef struct packed {
      logic signed [SDF_DATA_WIDTH-1:0] re;
      logic signed [SDF_DATA_WIDTH-1:0] im;
   } sdf_cplx_t;

   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

   // Round half up then halve; callers pass a sign-extended DATA_WIDTH+1 value.
   function automatic logic signed [SDF_CALC_WIDTH-1:0] half_round(
      input logic signed [SDF_CALC_WIDTH-1:0] v
   );
      return (v + 32'sd1) >>> 1;
   endfunction

endpackage

// File: rtl/sdf_delay_line.sv
// Enable-gated complex shift register of DELAY_DEPTH entries; oldest entry is presented
// on old_re/old_im and everything clears asynchronously to zero.
module sdf_delay_line
   import sdf_pkg::*;
#(
   parameter int DATA_WIDTH  = 16,
   parameter int DELAY_DEPTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [DATA_WIDTH-1:0] wr_re,
   input  logic [DATA_WIDTH-1:0] wr_im,
   output logic [DATA_WIDTH-1:0] old_re,
   output logic [DATA_WIDTH-1:0] old_im
);

   logic [DATA_WIDTH-1:0] mem_re [DELAY_DEPTH];
   logic [DATA_WIDTH-1:0] mem_im [DELAY_DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DELAY_DEPTH; i++) begin
            mem_re[i] <= '0;
            mem_im[i] <= '0;
         end
      end else if (en) begin
         mem_re[0] <= wr_re;
         mem_im[0] <= wr_im;
         for (int i = 1; i < DELAY_DEPTH; i++) begin
            mem_re[i] <= mem_re[i-1];
            mem_im[i] <= mem_im[i-1];
         end
      end
   end

   assign old_re = mem_re[DELAY_DEPTH-1];
   assign old_im = mem_im[DELAY_DEPTH-1];

endmodule

// File: rtl/r2sdf_stage.sv
// Radix-2 single-path delay-feedback butterfly stage with sample counter and valid strobes.
// Define SDF_SCALE_EN to halve (round half up) y0 and the fed-back y1.
module r2sdf_stage
   import sdf_pkg::*;
#(
   parameter int DATA_WIDTH  = 16,
   parameter int DELAY_DEPTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  di_en,
   input  logic [DATA_WIDTH-1:0] di_re,
   input  logic [DATA_WIDTH-1:0] di_im,
   output logic                  do_en,
   output logic [DATA_WIDTH-1:0] do_re,
   output logic [DATA_WIDTH-1:0] do_im,
   output logic                  do_sel
);

   localparam int CW = clog2(2 * DELAY_DEPTH);

   logic [CW-1:0]         cnt;
   logic                  primed;
   logic                  sel;
   logic [DATA_WIDTH-1:0] x1_re, x1_im;
   logic [DATA_WIDTH-1:0] wr_re, wr_im;
   logic signed [DATA_WIDTH:0] x0e_re, x0e_im, x1e_re, x1e_im;
   logic signed [DATA_WIDTH:0] y0_re, y0_im, y1_re, y1_im;
   logic [DATA_WIDTH-1:0] y0r_re, y0r_im, y1r_re, y1r_im;

   // 2N is a power of two, so the counter wraps on its own and its MSB is the half select.
   assign sel = cnt[CW-1];

   assign x0e_re = {di_re[DATA_WIDTH-1], di_re};
   assign x0e_im = {di_im[DATA_WIDTH-1], di_im};
   assign x1e_re = {x1_re[DATA_WIDTH-1], x1_re};
   assign x1e_im = {x1_im[DATA_WIDTH-1], x1_im};

   assign y0_re = x1e_re + x0e_re;
   assign y0_im = x1e_im + x0e_im;
   assign y1_re = x1e_re - x0e_re;
   assign y1_im = x1e_im - x0e_im;

`ifdef SDF_SCALE_EN
   assign y0r_re = DATA_WIDTH'(half_round(SDF_CALC_WIDTH'(y0_re)));
   assign y0r_im = DATA_WIDTH'(half_round(SDF_CALC_WIDTH'(y0_im)));
   assign y1r_re = DATA_WIDTH'(half_round(SDF_CALC_WIDTH'(y1_re)));
   assign y1r_im = DATA_WIDTH'(half_round(SDF_CALC_WIDTH'(y1_im)));
`else
   assign y0r_re = DATA_WIDTH'(y0_re);
   assign y0r_im = DATA_WIDTH'(y0_im);
   assign y1r_re = DATA_WIDTH'(y1_re);
   assign y1r_im = DATA_WIDTH'(y1_im);
`endif

   assign wr_re = sel ? y1r_re : di_re;
   assign wr_im = sel ? y1r_im : di_im;

   sdf_delay_line #(
      .DATA_WIDTH (DATA_WIDTH),
      .DELAY_DEPTH(DELAY_DEPTH)
   ) u_delay (
      .clk   (clk),
      .rst   (rst),
      .en    (di_en),
      .wr_re (wr_re),
      .wr_im (wr_im),
      .old_re(x1_re),
      .old_im(x1_im)
   );

   // The first sel=1 sample both primes the stage and is itself emitted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt    <= '0;
         primed <= 1'b0;
         do_en  <= 1'b0;
         do_re  <= '0;
         do_im  <= '0;
         do_sel <= 1'b0;
      end else begin
         do_en <= di_en & (primed | sel);
         if (di_en) begin
            cnt    <= cnt + CW'(1);
            primed <= primed | sel;
            do_sel <= sel;
            do_re  <= sel ? y0r_re : x1_re;
            do_im  <= sel ? y0r_im : x1_im;
         end
      end
   end

endmodule

// File: tb/tb_r2sdf_stage.sv
// Self-checking bench for r2sdf_stage (DATA_WIDTH=16, DELAY_DEPTH=4) using a frame-level
// butterfly model feeding an expected-output queue; honours SDF_SCALE_EN when defined.
module tb_r2sdf_stage;

   localparam int W = 16;
   localparam int N = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         di_en = 1'b0;
   logic [W-1:0] di_re = '0;
   logic [W-1:0] di_im = '0;
   logic         do_en;
   logic [W-1:0] do_re;
   logic [W-1:0] do_im;
   logic         do_sel;

   r2sdf_stage #(
      .DATA_WIDTH (W),
      .DELAY_DEPTH(N)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .di_en (di_en),
      .di_re (di_re),
      .di_im (di_im),
      .do_en (do_en),
      .do_re (do_re),
      .do_im (do_im),
      .do_sel(do_sel)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Scoreboard entry: {sel, re, im}
   logic [2*W:0] exp_q[$];
   logic         prev_en = 1'b0;
   logic [2*W:0] last_out = '0;

   // Frame model state
   logic [W-1:0] cur_re [N];
   logic [W-1:0] cur_im [N];
   logic [W-1:0] fb_re  [N];
   logic [W-1:0] fb_im  [N];
   int           pos = 0;
   bit           primed = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int sx(input logic signed [W-1:0] v);
      return int'(v);
   endfunction

   function automatic logic [W-1:0] red(input int s);
      int t;
      t = s;
`ifdef SDF_SCALE_EN
      t = (t + 1) >>> 1;
`endif
      return t[W-1:0];
   endfunction

   task automatic model_accept(input logic [W-1:0] re, input logic [W-1:0] im);
      int k;
      if (pos < N) begin
         if (primed) begin
            exp_q.push_back({1'b0, fb_re[pos], fb_im[pos]});
            prev_en = 1'b1;
         end
         cur_re[pos] = re;
         cur_im[pos] = im;
      end else begin
         k = pos - N;
         primed = 1;
         exp_q.push_back({1'b1, red(sx(cur_re[k]) + sx(re)), red(sx(cur_im[k]) + sx(im))});
         prev_en = 1'b1;
         fb_re[k] = red(sx(cur_re[k]) - sx(re));
         fb_im[k] = red(sx(cur_im[k]) - sx(im));
      end
      pos = (pos + 1) % (2 * N);
   endtask

   // One cycle: check what the previous cycle produced, then present new inputs.
   task automatic drive(input logic en, input logic [W-1:0] re, input logic [W-1:0] im);
      logic [2*W:0] e;
      @(negedge clk);
      check_val("do_en", {31'd0, do_en}, {31'd0, prev_en});
      if (do_en) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL sb_empty: observed re %0h im %0h expected no output", do_re, do_im);
         end else begin
            e = exp_q.pop_front();
            check_val("do_sel", {31'd0, do_sel}, {31'd0, e[2*W]});
            check_val("do_re", {16'd0, do_re}, {16'd0, e[2*W-1:W]});
            check_val("do_im", {16'd0, do_im}, {16'd0, e[W-1:0]});
            last_out = e;
         end
      end else begin
         check_val("hold_re", {16'd0, do_re}, {16'd0, last_out[2*W-1:W]});
         check_val("hold_im", {16'd0, do_im}, {16'd0, last_out[W-1:0]});
         check_val("hold_sel", {31'd0, do_sel}, {31'd0, last_out[2*W]});
      end
      di_en = en;
      di_re = re;
      di_im = im;
      prev_en = 1'b0;
      if (en) model_accept(re, im);
   endtask

   task automatic check_zero(input string tag);
      check_val({tag, "_en"}, {31'd0, do_en}, 32'd0);
      check_val({tag, "_re"}, {16'd0, do_re}, 32'd0);
      check_val({tag, "_im"}, {16'd0, do_im}, 32'd0);
      check_val({tag, "_sel"}, {31'd0, do_sel}, 32'd0);
   endtask

   task automatic clear_model();
      exp_q.delete();
      pos = 0;
      primed = 0;
      prev_en = 1'b0;
      last_out = '0;
   endtask

   // Asynchronous reset asserted between clock edges.
   task automatic do_reset();
      @(posedge clk);
      #2;
      rst = 1'b1;
      di_en = 1'b0;
      #1;
      check_zero("rst_async");
      @(negedge clk);
      check_zero("rst_hold");
      @(negedge clk);
      check_zero("rst_hold2");
      rst = 1'b0;
      clear_model();
   endtask

   task automatic random_frames(input int frames, input bit gaps);
      for (int i = 0; i < frames * 2 * N; i++) begin
         if (gaps && $urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(1, 3)) drive(1'b0, W'($urandom_range(0, 65535)), '0);
         end
         drive(1'b1, W'($urandom_range(0, 65535)), W'($urandom_range(0, 65535)));
      end
   endtask

   initial begin
      // Power-on reset
      repeat (2) @(negedge clk);
      check_zero("por");
      rst = 1'b0;
      clear_model();

      // Impulse frames
      for (int f = 0; f < 3; f++)
         for (int i = 0; i < 2 * N; i++)
            drive(1'b1, (i == 0) ? W'(1) : W'(0), '0);

      // DC 100+j50
      for (int i = 0; i < 4 * N; i++) drive(1'b1, W'(100), W'(50));

      // Overflow corners
      for (int i = 0; i < 4 * N; i++) drive(1'b1, W'(32767), W'(32767));
      for (int i = 0; i < 4 * N; i++) drive(1'b1, W'(16'h8000), W'(16'h8000));

      // Random data with stall gaps
      do_reset();
      random_frames(3, 1'b1);

      // Reset in the middle of a frame
      do_reset();
      for (int i = 0; i < 6; i++) drive(1'b1, W'($urandom_range(0, 65535)), W'($urandom_range(0, 65535)));
      do_reset();
      random_frames(3, 1'b1);
      random_frames(2, 1'b0);

      // Drain and confirm nothing is left outstanding
      repeat (3) drive(1'b0, '0, '0);
      check_val("sb_drain", exp_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
